mips_cpu_muldiv: RTL and testbench
==================================

// Module: mips_cpu_muldiv
// PURPOSE
//  Multi-cycle multiply/divide unit owning the HI/LO registers. Sits directly
//  downstream of the register file: op_a/op_b come from read_data_rs/read_data_rt.
//  Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in one
//  cycle. Control stalls the pipeline on busy; MFHI/MFLO read hi/lo for writeback.
// PARAMETERS
//  WIDTH  32  operand width; iterations per mul/div = WIDTH; counter = $clog2(WIDTH)+1 bits
// PORTS
//  clk    in   1      rising-edge clock
//  reset  in   1      asynchronous, active-high reset
//  start  in   1      issue op; sampled on rising clk edge, only honoured when busy=0
//  op     in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, else no-op
//  op_a   in   WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
//  op_b   in   WIDTH  rt operand (multiplier / divisor)
//  busy   out  1      mul/div in progress; pipeline must stall MFHI/MFLO/new mul-div
//  done   out  1      one-cycle pulse: hi/lo just updated by a mul/div
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (async, any time incl. mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0,
//    counter=0; in-flight op discarded, no done pulse ever produced for it.
//  - FSM: IDLE -> RUN -> FINISH -> IDLE.
//    IDLE: start & op in {MULT..DIVU}: latch operands/op, compute magnitudes (signed ops)
//      and result sign flags, counter=0, go RUN. start & MTHI: hi<=op_a; MTLO: lo<=op_a;
//      stay IDLE, busy stays 0, no done. Other op codes: no effect.
//    RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle on
//      magnitudes; counter++; after WIDTH steps go FINISH.
//    FINISH: apply sign fix, write hi/lo, assert done next cycle, go IDLE.
//  - Timing: start sampled at edge E0 -> busy=1 after E0 ... E(WIDTH+1) drops busy,
//    updates hi/lo, raises done for exactly one cycle. Latency WIDTH+1 cycles (33).
//  - busy and done are registered; never both 1. done=0 for MTHI/MTLO.
//  - start while busy=1: ignored entirely (operands/op not latched, no queueing).
//  - hi/lo hold their old values throughout RUN; only updated in FINISH / MTHI / MTLO.
//  - MULT/MULTU: {hi,lo} = 2*WIDTH-bit product. MULT: product negated (two's complement,
//    full 64 bits) when operand signs differ.
//  - DIV/DIVU: lo = quotient, hi = remainder. DIV: quotient negated when signs differ;
//    remainder takes sign of dividend (truncating division).
//  - Divide by zero (DIV or DIVU): full latency still taken; hi=op_a, lo=all ones.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap, wraps).
//  - Magnitude of 0x80000000 handled as unsigned 0x80000000 (WIDTH-bit unsigned datapath).
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> 33 cycles later hi=0xFFFFFFFE lo=0x00000001,
//    done high exactly 1 cycle, busy high 33 cycles.
//  2 MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; MULT 0x80000000*0x80000000
//    -> hi=0x40000000 lo=0.
//  3 DIV -7/2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 7/-2 -> lo=0xFFFFFFFD hi=1;
//    DIVU 7/2 -> lo=3 hi=1.
//  4 DIVU 0x1234/0 -> hi=0x1234 lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  5 MTHI 0xDEADBEEF then MTLO 0x12345678 in IDLE -> hi/lo updated next edge, busy/done
//    stay 0; start MULTU during busy -> ignored, original result unchanged.
//  6 reset asserted mid-cycle at RUN step 10 of a DIV -> busy=0, hi=lo=0 immediately
//    (before next edge), no done; new MULTU 3*4 afterwards -> lo=12 hi=0.

Source files
------------

// File: rtl/mips_cpu_muldiv_if.sv
// Issue/result bundle between pipeline control and the multiply/divide unit.
// The control side (master) issues ops and reads busy/done/hi/lo.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, op_a, op_b, input busy, done, hi, lo);
  modport slave  (input start, op, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// MULT/MULTU/DIV/DIVU run one bit per cycle on operand magnitudes, with the
// sign fixed up in a final cycle; MTHI/MTLO complete in a single cycle.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mips_cpu_muldiv_if.slave    bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n;      // mul: upper product half; div: partial remainder
  logic [WIDTH-1:0] q, q_n;          // mul: multiplier/lower half; div: dividend/quotient
  logic [WIDTH-1:0] b_q, b_n;        // multiplicand / divisor magnitude
  logic             is_div, is_div_n;
  logic             neg_lo, neg_lo_n; // negate product or quotient
  logic             neg_hi, neg_hi_n; // negate remainder (dividend was negative)
  logic             div0, div0_n;
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n;
  logic             busy, busy_n, done, done_n;

  // Scratch values for the datapath step and sign fix-up
  logic             sgn;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted, divisor;
  logic [2*WIDTH-1:0] prod;

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

  // Next-state, datapath step and HI/LO write-back
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    q_n      = q;
    b_n      = b_q;
    is_div_n = is_div;
    neg_lo_n = neg_lo;
    neg_hi_n = neg_hi;
    div0_n   = div0;
    hi_n     = hi;
    lo_n     = lo;
    done_n   = 1'b0;

    // Signed ops have op[0]==0; magnitude of the most negative value wraps to
    // the same bit pattern, which the unsigned datapath reads correctly.
    sgn     = ~bus.op[0];
    a_mag   = (sgn && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    b_mag   = (sgn && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    sum     = {1'b0, rem} + (q[0] ? {1'b0, b_q} : '0);
    shifted = {rem, q[WIDTH-1]};
    divisor = {1'b0, b_q};
    prod    = {rem, q};

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              rem_n    = '0;
              q_n      = a_mag;
              b_n      = b_mag;
              is_div_n = bus.op[1];
              neg_lo_n = sgn && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
              neg_hi_n = sgn && bus.op_a[WIDTH-1];
              div0_n   = (bus.op_b == '0);
              cnt_n    = '0;
              state_n  = RUN;
            end
            OP_MTHI: hi_n = bus.op_a;
            OP_MTLO: lo_n = bus.op_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div) begin
          // Restoring step; with a zero divisor every bit "fits", so the
          // dividend shifts into rem and the quotient fills with ones.
          if (shifted >= divisor) begin
            rem_n = WIDTH'(shifted - divisor);
            q_n   = {q[WIDTH-2:0], 1'b1};
          end else begin
            rem_n = shifted[WIDTH-1:0];
            q_n   = {q[WIDTH-2:0], 1'b0};
          end
        end else begin
          rem_n = sum[WIDTH:1];
          q_n   = {sum[0], q[WIDTH-1:1]};
        end
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_n = FINISH;
      end
      FINISH: begin
        if (is_div) begin
          hi_n = neg_hi ? -rem : rem;
          lo_n = div0 ? '1 : (neg_lo ? -q : q);
        end else begin
          prod = neg_lo ? -prod : prod;
          {hi_n, lo_n} = prod;
        end
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      q      <= '0;
      b_q    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rem    <= rem_n;
      q      <= q_n;
      b_q    <= b_n;
      is_div <= is_div_n;
      neg_lo <= neg_lo_n;
      neg_hi <= neg_hi_n;
      div0   <= div0_n;
      hi     <= hi_n;
      lo     <= lo_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: result table plus hand sequences for
// MTHI/MTLO, start-while-busy and reset in the middle of a divide.
module tb_mips_cpu_muldiv;
  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
  localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, NOP = 3'b110;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [12];

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Present an op for exactly one rising edge; returns at the falling edge after it
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.op_a  = a;
    bus.op_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts falling edges with busy high, bounded so a stuck unit cannot hang the run
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    int pre;
    logic seen_done;

    tbl[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1]  = '{MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tbl[2]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[3]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[4]  = '{DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[5]  = '{DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    tbl[6]  = '{DIVU,  32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
    tbl[7]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[8]  = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[9]  = '{DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC};
    tbl[10] = '{MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
    tbl[11] = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    bus.start = 1'b0;
    bus.op    = NOP;
    bus.op_a  = '0;
    bus.op_b  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    reset = 1'b0;

    // Table: latency, single-cycle done, result
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_idle(cyc);
      check($sformatf("v%0d_busy_cycles", i), 32'(cyc), 32'd33);
      check($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
      check($sformatf("v%0d_hi", i), bus.hi, tbl[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, tbl[i].lo);
      @(negedge clk);
      check($sformatf("v%0d_done_drop", i), 32'(bus.done), 32'd0);
    end

    // MTHI / MTLO complete in one cycle without busy or done
    issue(MTHI, 32'hDEAD_BEEF, 32'h0);
    check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    check("mthi_busy", 32'(bus.busy), 32'd0);
    check("mthi_done", 32'(bus.done), 32'd0);
    issue(MTLO, 32'h1234_5678, 32'h0);
    check("mtlo_lo", bus.lo, 32'h1234_5678);
    check("mtlo_hi_kept", bus.hi, 32'hDEAD_BEEF);
    check("mtlo_done", 32'(bus.done), 32'd0);
    issue(NOP, 32'h5555_5555, 32'h1);
    check("nop_hi", bus.hi, 32'hDEAD_BEEF);
    check("nop_lo", bus.lo, 32'h1234_5678);
    check("nop_busy", 32'(bus.busy), 32'd0);

    // Starts during busy are dropped, including MTHI
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    bus.op    = MULTU;
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd4;
    @(negedge clk);
    bus.op    = MTHI;
    bus.op_a  = 32'h5555_5555;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign_hi_hold", bus.hi, 32'hDEAD_BEEF);
    pre = 2;
    wait_idle(cyc);
    check("ign_busy_cycles", 32'(cyc + pre), 32'd33);
    check("ign_hi", bus.hi, 32'hFFFF_FFFE);
    check("ign_lo", bus.lo, 32'h0000_0001);
    repeat (3) @(negedge clk);
    check("ign_not_queued", 32'(bus.busy), 32'd0);

    // Reset in the middle of a divide: immediate clear, no done afterwards
    issue(DIV, 32'h0000_0100, 32'h0000_0003);
    repeat (10) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    check("mid_hi_hold", bus.hi, 32'hFFFF_FFFE);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_done |= bus.done;
    end
    check("arst_no_done", 32'(seen_done), 32'd0);
    check("arst_idle", 32'(bus.busy), 32'd0);
    issue(MULTU, 32'd3, 32'd4);
    wait_idle(cyc);
    check("post_busy_cycles", 32'(cyc), 32'd33);
    check("post_hi", bus.hi, 32'd0);
    check("post_lo", bus.lo, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
